// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_pkg
// Description : Shared 640x480@60 VGA timing constants and a window helper.
//               The sprite/playfield logic imports these same bounds so that
//               every block agrees on where the visible area sits.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_timing_pkg;

    localparam int CNT_W       = 10;   // width of hCount / vCount

    // Horizontal timing, in pixels. Line starts with the sync pulse.
    localparam int H_TOTAL     = 800;
    localparam int H_SYNC_END  = 96;   // sync low for 0..H_SYNC_END-1
    localparam int H_VIS_START = 144;  // first visible column
    localparam int H_VIS_END   = 784;  // one past the last visible column

    // Vertical timing, in lines. Frame starts with the sync pulse.
    localparam int V_TOTAL     = 525;
    localparam int V_SYNC_END  = 2;
    localparam int V_VIS_START = 35;
    localparam int V_VIS_END   = 515;

    // True when lo <= pos < hi_excl.
    function automatic logic in_window(
        input logic [CNT_W-1:0] pos,
        input int               lo,
        input int               hi_excl
    );
        return (int'(pos) >= lo) && (int'(pos) < hi_excl);
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_timing_gen_pix_en_div.sv
`default_nettype none
// ============================================================================
// Module      : pix_en_div
// Description : Divides the system clock by CLK_DIV and produces a registered
//               one-clk pixel strobe, high while the divider sits at its last
//               count (i.e. the cycle before the pixel counters advance).
// Ports       : clk    - system clock
//               rst    - synchronous active-high reset
//               pix_en - one-clk pixel strobe (registered)
// Revision    : 1.0 - initial release
// ============================================================================
module pix_en_div #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    output logic pix_en
);
    import vga_timing_pkg::*;

    localparam int                 c_DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [c_DIV_W-1:0] c_DIV_MAX = c_DIV_W'(CLK_DIV - 1);

    logic [c_DIV_W-1:0] r_div;
    logic [c_DIV_W-1:0] w_div_next;
    logic               r_pix_en;

    always_comb begin
        w_div_next = (r_div == c_DIV_MAX) ? '0 : r_div + c_DIV_W'(1);
    end

    // The strobe is registered from the next divider value so that it is
    // exactly (div == CLK_DIV-1) while still being a flop output.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div    <= '0;
            r_pix_en <= 1'b0;
        end else begin
            r_div    <= w_div_next;
            r_pix_en <= (w_div_next == c_DIV_MAX);
        end
    end

    assign pix_en = r_pix_en;

endmodule
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_gen
// Description : VGA raster timing generator. Produces pixel/line counters,
//               active-low syncs, the visible-area flag, line/frame ticks and
//               a free-running frame counter. Every output is a flop.
// Ports       : clk         - system clock (only clock used)
//               rst         - synchronous active-high reset
//               hCount      - current pixel column 0..H_TOTAL-1
//               vCount      - current line 0..V_TOTAL-1
//               hSync       - horizontal sync, active-low
//               vSync       - vertical sync, active-low
//               bright      - (hCount, vCount) inside the 640x480 window
//               pix_en      - one-clk strobe before the counters advance
//               line_tick   - one-clk pulse after each hCount wrap
//               frame_tick  - one-clk pulse after each frame wrap
//               frame_count - completed frames, modulo 2^16
// Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
    parameter int CLK_DIV = 4,
    parameter int H_TOTAL = vga_timing_pkg::H_TOTAL,
    parameter int V_TOTAL = vga_timing_pkg::V_TOTAL
) (
    input  logic        clk,
    input  logic        rst,
    output logic [9:0]  hCount,
    output logic [9:0]  vCount,
    output logic        hSync,
    output logic        vSync,
    output logic        bright,
    output logic        pix_en,
    output logic        line_tick,
    output logic        frame_tick,
    output logic [15:0] frame_count
);
    import vga_timing_pkg::*;

    localparam logic [9:0] c_H_MAX = 10'(H_TOTAL - 1);
    localparam logic [9:0] c_V_MAX = 10'(V_TOTAL - 1);

    logic        w_pix_en;
    logic        w_h_wrap;
    logic        w_v_wrap;
    logic [9:0]  w_h_next;
    logic [9:0]  w_v_next;

    logic [9:0]  r_h_count;
    logic [9:0]  r_v_count;
    logic        r_hsync;
    logic        r_vsync;
    logic        r_bright;
    logic        r_line_tick;
    logic        r_frame_tick;
    logic [15:0] r_frame_count;

    pix_en_div #(
        .CLK_DIV (CLK_DIV)
    ) u_pix_en_div (
        .clk    (clk),
        .rst    (rst),
        .pix_en (w_pix_en)
    );

    always_comb begin
        w_h_wrap = w_pix_en && (r_h_count == c_H_MAX);
        w_v_wrap = w_h_wrap && (r_v_count == c_V_MAX);

        w_h_next = r_h_count;
        if (w_pix_en) begin
            w_h_next = w_h_wrap ? 10'd0 : r_h_count + 10'd1;
        end

        w_v_next = r_v_count;
        if (w_h_wrap) begin
            w_v_next = w_v_wrap ? 10'd0 : r_v_count + 10'd1;
        end
    end

    // Syncs and bright are decoded from the next counts so they line up with
    // the counter values presented in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_h_count     <= '0;
            r_v_count     <= '0;
            r_hsync       <= 1'b0;
            r_vsync       <= 1'b0;
            r_bright      <= 1'b0;
            r_line_tick   <= 1'b0;
            r_frame_tick  <= 1'b0;
            r_frame_count <= '0;
        end else begin
            r_h_count    <= w_h_next;
            r_v_count    <= w_v_next;
            r_hsync      <= !in_window(w_h_next, 0, H_SYNC_END);
            r_vsync      <= !in_window(w_v_next, 0, V_SYNC_END);
            r_bright     <= in_window(w_h_next, H_VIS_START, H_VIS_END) &&
                            in_window(w_v_next, V_VIS_START, V_VIS_END);
            r_line_tick  <= w_h_wrap;
            r_frame_tick <= w_v_wrap;
            if (w_v_wrap) begin
                r_frame_count <= r_frame_count + 16'd1;
            end
        end
    end

    assign hCount      = r_h_count;
    assign vCount      = r_v_count;
    assign hSync       = r_hsync;
    assign vSync       = r_vsync;
    assign bright      = r_bright;
    assign pix_en      = w_pix_en;
    assign line_tick   = r_line_tick;
    assign frame_tick  = r_frame_tick;
    assign frame_count = r_frame_count;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_timing_gen
// Description : Self-checking bench for vga_timing_gen. Counters are jumped to
//               points of interest so whole frames need not be simulated.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  hCount;
    logic [9:0]  vCount;
    logic        hSync;
    logic        vSync;
    logic        bright;
    logic        pix_en;
    logic        line_tick;
    logic        frame_tick;
    logic [15:0] frame_count;

    int checks = 0;
    int errors = 0;

    // Static jump targets (force needs non-automatic operands).
    logic [9:0]  jh;
    logic [9:0]  jv;
    logic [15:0] jf;

    typedef struct {
        logic [9:0] h0;
        logic [9:0] v0;
        logic [9:0] eh;
        logic [9:0] ev;
        logic       ehs;
        logic       evs;
        logic       eb;
        logic       elt;
        logic       eft;
    } vec_t;

    vec_t vecs[13];

    vga_timing_gen #(
        .CLK_DIV (4),
        .H_TOTAL (800),
        .V_TOTAL (525)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .hCount      (hCount),
        .vCount      (vCount),
        .hSync       (hSync),
        .vSync       (vSync),
        .bright      (bright),
        .pix_en      (pix_en),
        .line_tick   (line_tick),
        .frame_tick  (frame_tick),
        .frame_count (frame_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Returns at a negedge where pix_en is high (counters advance next edge).
    task automatic wait_pix_en(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (pix_en !== 1'b1 && n < 8) begin
            @(negedge clk);
            n++;
        end
        if (pix_en !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL %s: pix_en timeout got %b expected 1", tag, pix_en);
        end
    endtask

    task jump;
        force dut.r_h_count = jh;
        force dut.r_v_count = jv;
        #1;
        release dut.r_h_count;
        release dut.r_v_count;
    endtask

    task jump_fc;
        force dut.r_h_count     = jh;
        force dut.r_v_count     = jv;
        force dut.r_frame_count = jf;
        #1;
        release dut.r_h_count;
        release dut.r_v_count;
        release dut.r_frame_count;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " hCount"},      32'(hCount),      32'd0);
        check({tag, " vCount"},      32'(vCount),      32'd0);
        check({tag, " hSync"},       32'(hSync),       32'd0);
        check({tag, " vSync"},       32'(vSync),       32'd0);
        check({tag, " bright"},      32'(bright),      32'd0);
        check({tag, " pix_en"},      32'(pix_en),      32'd0);
        check({tag, " line_tick"},   32'(line_tick),   32'd0);
        check({tag, " frame_tick"},  32'(frame_tick),  32'd0);
        check({tag, " frame_count"}, 32'(frame_count), 32'd0);
    endtask

    // First pix_en in the 4th cycle after release, hCount 1 after that edge.
    task automatic check_restart(input string tag);
        for (int j = 1; j <= 12; j++) begin
            @(negedge clk);
            check($sformatf("%s pix_en j%0d", tag, j), 32'(pix_en), 32'((j % 4) == 3));
            check($sformatf("%s hCount j%0d", tag, j), 32'(hCount), 32'(j / 4));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //            h0      v0      eh      ev     hs    vs    b     lt    ft
        vecs[0]  = '{10'd142, 10'd35,  10'd143, 10'd35,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{10'd143, 10'd35,  10'd144, 10'd35,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{10'd782, 10'd514, 10'd783, 10'd514, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{10'd783, 10'd514, 10'd784, 10'd514, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{10'd143, 10'd515, 10'd144, 10'd515, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{10'd94,  10'd100, 10'd95,  10'd100, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{10'd95,  10'd100, 10'd96,  10'd100, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{10'd799, 10'd0,   10'd0,   10'd1,   1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[8]  = '{10'd799, 10'd1,   10'd0,   10'd2,   1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[9]  = '{10'd500, 10'd200, 10'd501, 10'd200, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{10'd798, 10'd34,  10'd799, 10'd34,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{10'd143, 10'd34,  10'd144, 10'd34,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{10'd799, 10'd524, 10'd0,   10'd0,   1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

        // Reset state.
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        // Counting from reset release.
        check_restart("release");
        check("release vCount", 32'(vCount), 32'd0);

        // Table of single-step points around syncs, window edges and wraps.
        for (int i = 0; i < 13; i++) begin
            wait_pix_en($sformatf("vec%0d", i));
            jh = vecs[i].h0;
            jv = vecs[i].v0;
            jump();
            @(negedge clk);
            check($sformatf("vec%0d hCount", i),     32'(hCount),     32'(vecs[i].eh));
            check($sformatf("vec%0d vCount", i),     32'(vCount),     32'(vecs[i].ev));
            check($sformatf("vec%0d hSync", i),      32'(hSync),      32'(vecs[i].ehs));
            check($sformatf("vec%0d vSync", i),      32'(vSync),      32'(vecs[i].evs));
            check($sformatf("vec%0d bright", i),     32'(bright),     32'(vecs[i].eb));
            check($sformatf("vec%0d line_tick", i),  32'(line_tick),  32'(vecs[i].elt));
            check($sformatf("vec%0d frame_tick", i), 32'(frame_tick), 32'(vecs[i].eft));
        end
        // The last vector is the only frame wrap so far.
        check("first frame frame_count", 32'(frame_count), 32'd1);
        @(negedge clk);
        check("tick width line_tick",  32'(line_tick),  32'd0);
        check("tick width frame_tick", 32'(frame_tick), 32'd0);

        // Frame counter rollover.
        wait_pix_en("rollover");
        jh = 10'd799;
        jv = 10'd524;
        jf = 16'hFFFF;
        jump_fc();
        @(negedge clk);
        check("rollover frame_count", 32'(frame_count), 32'd0);
        check("rollover frame_tick",  32'(frame_tick),  32'd1);
        check("rollover line_tick",   32'(line_tick),   32'd1);
        check("rollover hCount",      32'(hCount),      32'd0);
        check("rollover vCount",      32'(vCount),      32'd0);
        @(negedge clk);
        check("rollover frame_tick drop", 32'(frame_tick), 32'd0);

        // Reset in the middle of the visible area.
        jf = 16'h0005;
        wait_pix_en("midreset");
        jh = 10'd399;
        jv = 10'd300;
        jump_fc();
        @(negedge clk);
        check("midreset hCount pre", 32'(hCount), 32'd400);
        check("midreset bright pre", 32'(bright), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("midreset");
        rst = 1'b0;
        check_restart("midrestart");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
